// File: rtl/spi_flash_fetch_ctrl.sv
// spi_flash_fetch_ctrl
// Fetches one 32-bit little-endian word from a serial flash per request.
// Each request becomes a standard READ (0x03) in SPI mode 0: 8 command bits,
// 24 address bits, then 32 data bits.
// The response is a single-cycle rsp_valid pulse. rsp_data keeps its value
// until the next pulse.
module spi_flash_fetch_ctrl #(
  parameter int CLK_DIV = 2,  // SCK half-period in clk cycles, 1..15
  parameter int CS_HOLD = 2   // minimum cs_n high time in clk cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_GAP
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [3:0] HOLD_LAST = 4'(CS_HOLD);
  localparam logic [5:0] BIT_LAST  = 6'd63;
  localparam logic [5:0] ADDR_FIRST = 6'd8;
  localparam logic [5:0] DATA_FIRST = 6'd32;

  state_e      state_q;
  logic [3:0]  div_cnt_q;    // clk cycles spent in the current SCK phase
  logic [5:0]  bit_cnt_q;    // bit index across CMD, ADDR and DATA (0..63)
  logic [31:0] tx_sh_q;      // {command, word-aligned address}, MSB leaves first
  logic [31:0] rx_sh_q;      // data bits in arrival order; byte0 ends in [31:24]
  logic [3:0]  gap_cnt_q;    // cs_n-high cycles elapsed since DONE, inclusive
  logic        req_ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        cs_n_q;
  logic        sck_q;
  logic        mosi_q;

  logic        phase_end;
  logic [5:0]  bit_cnt_d;
  logic        mosi_d;
  logic [31:0] rsp_data_d;
  logic        unused_addr_lsbs;

  // The two low address bits are dropped: every fetch is word aligned.
  assign unused_addr_lsbs = ^req_addr[1:0];

  // The current SCK half-period ends on this clk cycle.
  assign phase_end = (div_cnt_q == DIV_LAST);

  // Index of the bit that starts at the next SCK falling edge.
  assign bit_cnt_d = bit_cnt_q + 6'd1;

  // The next MOSI bit comes from the shifter until the address is fully sent.
  // MOSI is held at 0 for the whole data phase.
  assign mosi_d = ~bit_cnt_d[5] & tx_sh_q[30];

  // Byte0 arrives first and lands in the top byte of rx_sh_q.
  // Swap the bytes so the returned word is little-endian.
  assign rsp_data_d = {rx_sh_q[7:0], rx_sh_q[15:8], rx_sh_q[23:16], rx_sh_q[31:24]};

  // Transaction sequencer. Every output comes straight from a register.
  // NOTE: every register here uses non-blocking (<=) assignments. Each branch
  // then reads the values from before this edge, whatever order the branches run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      gap_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      // rsp_valid is high for one cycle only: it is set again only on the DONE entry.
      rsp_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            state_q     <= ST_CMD;
            tx_sh_q     <= {CMD_READ, req_addr[23:2], 2'b00};
            mosi_q      <= CMD_READ[7];
            cs_n_q      <= 1'b0;
            sck_q       <= 1'b0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        ST_CMD, ST_ADDR, ST_DATA: begin
          if (!phase_end) begin
            div_cnt_q <= div_cnt_q + 4'd1;
          end else begin
            div_cnt_q <= '0;
            if (!sck_q) begin
              // Rising edge: the flash output has been stable for a full low phase.
              sck_q <= 1'b1;
              if (state_q == ST_DATA) begin
                rx_sh_q <= {rx_sh_q[30:0], spi_miso};
              end
            end else begin
              // Falling edge: end of the bit. Start the next bit or finish.
              sck_q <= 1'b0;
              if (bit_cnt_q == BIT_LAST) begin
                state_q     <= ST_DONE;
                cs_n_q      <= 1'b1;
                mosi_q      <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rsp_data_d;
              end else begin
                bit_cnt_q <= bit_cnt_d;
                tx_sh_q   <= {tx_sh_q[30:0], 1'b0};
                mosi_q    <= mosi_d;
                if (bit_cnt_d == ADDR_FIRST) begin
                  state_q <= ST_ADDR;
                end else if (bit_cnt_d == DATA_FIRST) begin
                  state_q <= ST_DATA;
                end
              end
            end
          end
        end

        ST_DONE: begin
          // DONE is the first cs_n-high cycle. The gap counter starts at the second.
          gap_cnt_q <= 4'd2;
          if (HOLD_LAST <= 4'd1) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt_q >= HOLD_LAST) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          cs_n_q      <= 1'b1;
          sck_q       <= 1'b0;
          mosi_q      <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;

endmodule
